// File: rtl/xbus_protocol_checker.sv
// Passive XBUS monitor: follows arbitration, address and data phases,
// latches sticky protocol-violation flags and counts transfers/errors.
module xbus_protocol_checker #(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MAX_WAIT    = 16,
    parameter int CNT_W       = 16
) (
    input  logic                           sig_clock,
    input  logic                           sig_reset,
    input  logic                           has_checks,
    input  logic                           clr_errors,
    input  logic [NUM_MASTERS-1:0]         sig_request,
    input  logic [NUM_MASTERS-1:0]         sig_grant,
    input  logic [ADDR_W-1:0]              sig_addr,
    input  logic [1:0]                     sig_size,
    input  logic                           sig_read,
    input  logic                           sig_write,
    input  logic                           sig_bip,
    input  logic [DATA_W-1:0]              sig_data,
    input  logic                           sig_wait,
    input  logic                           sig_error,
    output logic [1:0]                     phase,
    output logic [7:0]                     err_flags,
    output logic                           err_irq,
    output logic                           xfer_done,
    output logic [$clog2(NUM_MASTERS)-1:0] xfer_master,
    output logic                           xfer_write,
    output logic [3:0]                     xfer_beats,
    output logic [CNT_W-1:0]               xfer_count,
    output logic [CNT_W-1:0]               err_count
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam logic [8:0] WAIT_LIM = 9'(MAX_WAIT);
    localparam logic [NUM_MASTERS-1:0] G_ONE = 1;

    typedef enum logic [1:0] {
        PH_ARB  = 2'd0,
        PH_ADDR = 2'd1,
        PH_WR   = 2'd2,
        PH_RD   = 2'd3
    } phase_t;

    phase_t                 r_phase;
    phase_t                 w_phase_nxt;
    logic                   w_xfer_end;

    logic [MW-1:0]          r_master;
    logic                   r_write;
    logic [3:0]             r_beats;
    logic [3:0]             r_beat;
    logic [8:0]             r_wait_cnt;
    logic                   r_prev_wr_wait;
    logic [DATA_W-1:0]      r_prev_data;

    logic                   r_done;
    logic [CNT_W-1:0]       r_xfer_count;
    logic [CNT_W-1:0]       r_err_count;
    logic [7:0]             r_flags;
    logic                   r_irq;

    logic                   w_data_ph;
    logic                   w_beat_done;
    logic                   w_grant_any;
    logic [MW-1:0]          w_grant_idx;
    logic [3:0]             w_beats_nxt;
    logic [3:0]             w_last;
    logic [7:0]             w_raw;
    logic [7:0]             w_viol;
    logic                   w_any_viol;
    logic                   w_unused_addr;

    // The address bus is carried past the checker but never inspected.
    assign w_unused_addr = ^sig_addr;

    assign w_data_ph   = (r_phase == PH_WR) || (r_phase == PH_RD);
    assign w_beat_done = w_data_ph && !sig_wait;
    assign w_grant_any = |sig_grant;
    assign w_beats_nxt = 4'd1 << sig_size;
    assign w_last      = r_beats - 4'd1;

    // Lowest set grant bit wins the master index.
    always_comb begin
        w_grant_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (sig_grant[i]) w_grant_idx = MW'(i);
        end
    end

    // Violation detection for the current cycle.
    always_comb begin
        w_raw    = '0;
        w_raw[0] = |(sig_grant & (sig_grant - G_ONE));
        w_raw[1] = |(sig_grant & ~sig_request);
        w_raw[2] = (r_phase == PH_ADDR) && sig_read && sig_write;
        w_raw[3] = (r_phase == PH_ADDR) && !sig_read && !sig_write;
        w_raw[4] = (r_phase == PH_WR) && r_prev_wr_wait &&
                   (sig_data != r_prev_data);
        w_raw[5] = w_data_ph && sig_error && sig_wait;
        w_raw[6] = w_data_ph && sig_wait && (r_wait_cnt == WAIT_LIM);
        w_raw[7] = w_beat_done &&
                   ((sig_bip && (r_beat == w_last)) ||
                    (!sig_bip && (r_beat < w_last)));
    end

    assign w_viol     = has_checks ? w_raw : 8'h00;
    assign w_any_viol = |w_viol;

    // Phase state register.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) r_phase <= PH_ARB;
        else           r_phase <= w_phase_nxt;
    end

    // Next phase and end-of-transfer detection.
    always_comb begin
        w_phase_nxt = r_phase;
        w_xfer_end  = 1'b0;
        unique case (r_phase)
            PH_ARB: begin
                if (w_grant_any) w_phase_nxt = PH_ADDR;
            end
            PH_ADDR: begin
                w_phase_nxt = sig_write ? PH_WR : PH_RD;
            end
            PH_WR, PH_RD: begin
                if (w_beat_done && !sig_bip) begin
                    w_phase_nxt = PH_ARB;
                    w_xfer_end  = 1'b1;
                end
            end
        endcase
    end

    // Latch granted master and transfer shape.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            r_master <= '0;
            r_write  <= 1'b0;
            r_beats  <= 4'd0;
        end else begin
            if (r_phase == PH_ARB && w_grant_any) r_master <= w_grant_idx;
            if (r_phase == PH_ADDR) begin
                r_write <= sig_write;
                r_beats <= w_beats_nxt;
            end
        end
    end

    // Beat index, wait run length and previous write-data history.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            r_beat         <= 4'd0;
            r_wait_cnt     <= 9'd0;
            r_prev_wr_wait <= 1'b0;
            r_prev_data    <= '0;
        end else begin
            if (r_phase == PH_ADDR) begin
                r_beat <= 4'd0;
            end else if (w_beat_done && r_beat != 4'hF) begin
                r_beat <= r_beat + 4'd1;
            end
            // Stops one past the limit so a long run flags only once.
            if (w_data_ph && sig_wait) begin
                if (r_wait_cnt <= WAIT_LIM) r_wait_cnt <= r_wait_cnt + 9'd1;
            end else begin
                r_wait_cnt <= 9'd0;
            end
            r_prev_wr_wait <= (r_phase == PH_WR) && sig_wait;
            r_prev_data    <= sig_data;
        end
    end

    // Completion pulse and saturating transfer counter.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            r_done       <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            r_done <= w_xfer_end;
            if (w_xfer_end && r_xfer_count != '1) begin
                r_xfer_count <= r_xfer_count + CNT_W'(1);
            end
        end
    end

    // Sticky flags, error counter and interrupt; new violations beat a clear.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            r_flags     <= 8'h00;
            r_err_count <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= |r_flags;
            if (clr_errors) begin
                r_flags     <= w_viol;
                r_err_count <= {{(CNT_W-1){1'b0}}, w_any_viol};
            end else begin
                r_flags <= r_flags | w_viol;
                if (w_any_viol && r_err_count != '1) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
        end
    end

    assign phase       = r_phase;
    assign err_flags   = r_flags;
    assign err_irq     = r_irq;
    assign xfer_done   = r_done;
    assign xfer_master = r_master;
    assign xfer_write  = r_write;
    assign xfer_beats  = r_beats;
    assign xfer_count  = r_xfer_count;
    assign err_count   = r_err_count;

endmodule
